gf180mcu_oai21_bist_seq: RTL
============================

GF180MCU_OAI21_BIST_SEQ -- requirements
Module: gf180mcu_oai21_bist_seq

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter SETTLE, default 1, SHALL set the number of settle cycles between applying a vector and sampling it; legal range 1..7.
REQ-003 Parameter LOOPS, default 1, SHALL set the number of full passes over the 8 input vectors; legal range 1..15.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RN  input  1  asynchronous active-low reset.
REQ-006 START  input  1  request to begin a test run; sampled on CLK.
REQ-007 ZN_IN  input  1  ZN returned from the OAI21 cell under test.
REQ-008 A1  output  1  drive to the cell-under-test A1 input; registered.
REQ-009 A2  output  1  drive to the cell-under-test A2 input; registered.
REQ-010 B  output  1  drive to the cell-under-test B input; registered.
REQ-011 BUSY  output  1  high while a run is in progress.
REQ-012 DONE  output  1  high from run completion until the next accepted START or reset.
REQ-013 PASS  output  1  equals DONE AND (ERR_CNT == 0).
REQ-014 ERR_CNT  output  4  count of mismatches, saturating.
REQ-015 VDD and VSS, each inout, 1 bit: supply pins carried for library consistency and SHALL have no functional effect.

Function
REQ-016 The state machine SHALL have four states: IDLE, WAIT, SAMPLE and FINISH.
REQ-017 A 3-bit vector index VEC SHALL drive {A1,A2,B} = VEC, with A1 as the MSB.
REQ-018 The expected response SHALL be EXP = NOT((A1 OR A2) AND B), computed from the registered A1/A2/B.
REQ-019 Start from IDLE or FINISH: at the edge where START=1, the block SHALL set VEC=0, the loop count to 0, ERR_CNT=0, DONE=0 and BUSY=1, drive {A1,A2,B}=000, load the settle counter with SETTLE-1, and enter WAIT.
REQ-020 In WAIT the settle counter SHALL decrement each cycle, and the block SHALL enter SAMPLE on the edge at which the counter is 0.
REQ-021 Leaving SAMPLE, the block SHALL compare ZN_IN to EXP at that edge; on a mismatch ERR_CNT increments, holding at 15 (no wrap).
REQ-022 Leaving SAMPLE when VEC<7 or when it is not the last loop: VEC increments (7 wraps to 0, incrementing the loop count), the new vector is driven, the settle counter is reloaded, and the block enters WAIT.
REQ-023 Leaving SAMPLE when VEC=7 on loop LOOPS-1: the block enters FINISH with BUSY=0 and DONE=1, and A1/A2/B return to 0.
REQ-024 Each vector SHALL take SETTLE+1 cycles; DONE SHALL be visible after edge k+8*(SETTLE+1)*LOOPS, where k is the START edge.
REQ-025 START while BUSY=1 SHALL be ignored, with no restart and no counter disturbance.
REQ-026 In FINISH the block SHALL hold DONE, PASS and ERR_CNT until START is accepted (REQ-019).
REQ-027 ZN_IN SHALL be ignored in every state other than SAMPLE.

Reset
REQ-028 RN low SHALL immediately force IDLE and set A1=A2=B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, VEC=0, the loop count to 0 and the settle counter to 0.
REQ-029 Reset asserted mid-run SHALL abort the run with no DONE pulse.
REQ-030 After RN rises, the block SHALL stay in IDLE until START is sampled high.

Verification
REQ-031 Correct model (ZN_IN = OAI21 of the outputs), SETTLE=1, LOOPS=1, START at edge k -> BUSY=1 from k to k+16, DONE=1 and PASS=1 after k+16, ERR_CNT=0, and A1/A2/B walk through 000..111.
REQ-032 ZN_IN stuck at 0, defaults -> ERR_CNT=5, PASS=0, DONE=1.
REQ-033 ZN_IN stuck at 1, SETTLE=3 -> ERR_CNT=3, DONE after k+32.
REQ-034 ZN_IN stuck at 0, LOOPS=4 -> the count saturates: ERR_CNT=15, not 20 and not wrapped to 4; DONE after k+64.
REQ-035 START pulsed again at k+5 during a run -> no effect, and completion still occurs at k+16.
REQ-036 RN pulsed low at k+7 -> all outputs are 0 asynchronously and the block sits in IDLE; a new START then yields a clean run with PASS=1.

Source files
------------

// File: rtl/gf180mcu_oai21_bist_seq_if.sv
// Handshake/status bundle between the OAI21 BIST sequencer and its
// controller/cell-under-test.
interface gf180mcu_oai21_bist_seq_if;
  logic       START;
  logic       ZN_IN;
  logic       A1;
  logic       A2;
  logic       B;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] ERR_CNT;

  modport master (
    output START, ZN_IN,
    input  A1, A2, B, BUSY, DONE, PASS, ERR_CNT
  );

  modport slave (
    input  START, ZN_IN,
    output A1, A2, B, BUSY, DONE, PASS, ERR_CNT
  );
endinterface

// File: rtl/gf180mcu_oai21_bist_seq.sv
// Exhaustive BIST sequencer for a GF180MCU OAI21 cell: walks {A1,A2,B} over
// all 8 vectors LOOPS times, checks ZN after SETTLE cycles, counts mismatches.
module gf180mcu_oai21_bist_seq #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned LOOPS  = 1
) (
  input  logic                          CLK,
  input  logic                          RN,
  inout  wire                           VDD,
  inout  wire                           VSS,
  gf180mcu_oai21_bist_seq_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_FINISH
  } state_t;

  localparam logic [2:0] SETTLE_LD = 3'(SETTLE - 1);
  localparam logic [3:0] LAST_LOOP = 4'(LOOPS - 1);

  // Supply pins are carried only so the block matches the cell library pinout.
  wire w_unused_supply = VDD & VSS;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_vec,   w_vec_nxt;
  logic [3:0] r_loop,  w_loop_nxt;
  logic [2:0] r_cnt,   w_cnt_nxt;
  logic [2:0] r_drv,   w_drv_nxt;
  logic       r_busy,  w_busy_nxt;
  logic       r_done,  w_done_nxt;
  logic [3:0] r_err,   w_err_nxt;
  logic       w_exp;

  assign w_exp = ~((r_drv[2] | r_drv[1]) & r_drv[0]);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_loop_nxt  = r_loop;
    w_cnt_nxt   = r_cnt;
    w_drv_nxt   = r_drv;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;

    unique case (r_state)
      S_IDLE, S_FINISH: begin
        if (bus.START) begin
          w_vec_nxt   = '0;
          w_loop_nxt  = '0;
          w_err_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_drv_nxt   = '0;
          w_cnt_nxt   = SETTLE_LD;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_SAMPLE;
        else             w_cnt_nxt   = r_cnt - 3'd1;
      end

      S_SAMPLE: begin
        if ((bus.ZN_IN != w_exp) && (r_err != 4'hF)) w_err_nxt = r_err + 4'd1;
        if ((r_vec == 3'd7) && (r_loop == LAST_LOOP)) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_drv_nxt   = '0;
          w_state_nxt = S_FINISH;
        end else begin
          w_vec_nxt   = r_vec + 3'd1;
          w_drv_nxt   = r_vec + 3'd1;
          if (r_vec == 3'd7) w_loop_nxt = r_loop + 4'd1;
          w_cnt_nxt   = SETTLE_LD;
          w_state_nxt = S_WAIT;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state, including counters and the drive register, is cleared by
  // the asynchronous reset so an aborted run leaves nothing behind.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_loop  <= '0;
      r_cnt   <= '0;
      r_drv   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge.
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_loop  <= w_loop_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drv   <= w_drv_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.A1      = r_drv[2];
  assign bus.A2      = r_drv[1];
  assign bus.B       = r_drv[0];
  assign bus.BUSY    = r_busy;
  assign bus.DONE    = r_done;
  assign bus.PASS    = r_done & (r_err == 4'd0);
  assign bus.ERR_CNT = r_err;

endmodule
